loopback_fifo: RTL and testbench

- Parametrised byte-stream loopback engine between usb_cdc OUT (host->device) and IN (device->host) streams. Runs in the usb_cdc application clock domain.
- Adds the following over a bare wire loopback:
  - buffering FIFO of configurable depth
  - runtime-selectable modes: echo, uppercase, line-buffered, discard
  - retriggerable activity pulse for the status LED
  - discard counter

---
 rtl/loopback_pkg.sv | 20 ++
 rtl/sync_fifo.sv | 47 ++++
 rtl/loopback_fifo.sv | 107 ++++++++++
 tb/tb_loopback_fifo.sv | 285 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/loopback_pkg.sv
// Shared encodings and the byte transform for the usb_cdc loopback engine.
package loopback_pkg;

  typedef enum logic [1:0] {
    MODE_ECHO  = 2'd0,
    MODE_UPPER = 2'd1,
    MODE_LINE  = 2'd2,
    MODE_DROP  = 2'd3
  } mode_e;

  localparam logic [7:0] UPPER_LO    = 8'h61;
  localparam logic [7:0] UPPER_HI    = 8'h7A;
  localparam logic [7:0] CASE_OFFSET = 8'h20;

  function automatic logic [7:0] to_upper(input logic [7:0] b);
    if (b >= UPPER_LO && b <= UPPER_HI) return b - CASE_OFFSET;
    return b;
  endfunction

endpackage

// File: rtl/sync_fifo.sv
// Single-clock register-array FIFO; the extra pointer MSB separates full from empty.
module sync_fifo #(
  parameter int DEPTH = 16,
  parameter int WIDTH = 8,
  localparam int AW = $clog2(DEPTH)
) (
  input  logic             clk_i,
  input  logic             rstn_i,
  input  logic             wr_en,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             rd_en,
  output logic [WIDTH-1:0] rd_data,
  output logic             full,
  output logic             empty,
  output logic [AW:0]      level
);

  logic [AW:0]      wr_ptr;
  logic [AW:0]      rd_ptr;
  logic [WIDTH-1:0] mem [DEPTH];
  logic             do_wr;
  logic             do_rd;

  assign empty   = (wr_ptr == rd_ptr);
  assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign level   = wr_ptr - rd_ptr;
  assign rd_data = mem[rd_ptr[AW-1:0]];

  // A write into a full FIFO is only legal when the head slot is freed the same edge.
  assign do_wr = wr_en && (!full || rd_en);
  assign do_rd = rd_en && !empty;

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_wr) wr_ptr <= wr_ptr + (AW+1)'(1);
      if (do_rd) rd_ptr <= rd_ptr + (AW+1)'(1);
    end
  end

  always_ff @(posedge clk_i) begin
    if (do_wr) mem[wr_ptr[AW-1:0]] <= wr_data;
  end

endmodule

// File: rtl/loopback_fifo.sv
// Byte loopback between usb_cdc OUT and IN streams with buffering, mode transforms,
// line gating, a saturating drop counter and a retriggerable activity pulse.
module loopback_fifo
  import loopback_pkg::*;
#(
  parameter int         DEPTH      = 16,
  parameter int         ACT_CYCLES = 1200000,
  parameter logic [7:0] EOL_CHAR   = 8'h0A,
  parameter int         CNT_W      = 16,
  localparam int        LW         = $clog2(DEPTH) + 1,
  localparam int        AC_W       = $clog2(ACT_CYCLES + 1)
) (
  input  logic             clk_i,
  input  logic             rstn_i,
  input  logic [1:0]       mode_i,
  input  logic [7:0]       rx_data_i,
  input  logic             rx_valid_i,
  output logic             rx_ready_o,
  output logic [7:0]       tx_data_o,
  output logic             tx_valid_o,
  input  logic             tx_ready_i,
  output logic [1:0]       mode_o,
  output logic [LW-1:0]    level_o,
  output logic             act_o,
  output logic [CNT_W-1:0] drop_cnt_o
);

  mode_e            mode_q;
  logic [LW-1:0]    lines_pending;
  logic [AC_W-1:0]  act_cnt;
  logic [AC_W-1:0]  act_cnt_nxt;
  logic             act_q;
  logic [CNT_W-1:0] drop_cnt;

  logic             fifo_full;
  logic             fifo_empty;
  logic             fifo_wr;
  logic [7:0]       fifo_wr_data;
  logic [7:0]       fifo_rd_data;
  logic             rx_fire;
  logic             tx_fire;
  logic             line_open;
  logic             lp_inc;
  logic             lp_dec;

  sync_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (8)
  ) u_fifo (
    .clk_i   (clk_i),
    .rstn_i  (rstn_i),
    .wr_en   (fifo_wr),
    .wr_data (fifo_wr_data),
    .rd_en   (tx_fire),
    .rd_data (fifo_rd_data),
    .full    (fifo_full),
    .empty   (fifo_empty),
    .level   (level_o)
  );

  assign rx_ready_o   = (mode_q == MODE_DROP) ? 1'b1 : !fifo_full;
  assign rx_fire      = rx_valid_i && rx_ready_o;
  assign fifo_wr      = rx_fire && (mode_q != MODE_DROP);
  assign fifo_wr_data = (mode_q == MODE_UPPER) ? to_upper(rx_data_i) : rx_data_i;

  // Full override keeps lines longer than the FIFO from deadlocking line mode.
  assign line_open  = (mode_q != MODE_LINE) || (lines_pending != '0) || fifo_full;
  assign tx_valid_o = !fifo_empty && line_open;
  assign tx_data_o  = fifo_rd_data;
  assign tx_fire    = tx_valid_o && tx_ready_i;

  assign lp_inc = fifo_wr && (fifo_wr_data == EOL_CHAR);
  assign lp_dec = tx_fire && (fifo_rd_data == EOL_CHAR);

  assign mode_o     = mode_q;
  assign act_o      = act_q;
  assign drop_cnt_o = drop_cnt;

  always_comb begin
    act_cnt_nxt = act_cnt;
    if (rx_fire || tx_fire)   act_cnt_nxt = AC_W'(ACT_CYCLES);
    else if (act_cnt != '0)   act_cnt_nxt = act_cnt - AC_W'(1);
  end

  // Mode only changes while nothing is buffered, so buffered bytes keep their mode.
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      mode_q        <= MODE_ECHO;
      lines_pending <= '0;
      drop_cnt      <= '0;
      act_cnt       <= '0;
      act_q         <= 1'b0;
    end else begin
      if (fifo_empty && !fifo_wr) mode_q <= mode_e'(mode_i);

      if (lp_inc && !lp_dec)      lines_pending <= lines_pending + LW'(1);
      else if (!lp_inc && lp_dec) lines_pending <= lines_pending - LW'(1);

      if (rx_fire && (mode_q == MODE_DROP) && (drop_cnt != '1))
        drop_cnt <= drop_cnt + CNT_W'(1);

      act_cnt <= act_cnt_nxt;
      act_q   <= (act_cnt_nxt != '0);
    end
  end

endmodule

// File: tb/tb_loopback_fifo.sv
// Randomised and directed bench for loopback_fifo with a queue-based reference model.
module tb_loopback_fifo;

  localparam int DEPTH = 16;
  localparam int ACT   = 20;
  localparam int CNT_W = 16;
  localparam int LW    = $clog2(DEPTH) + 1;

  logic             clk = 1'b0;
  logic             rstn;
  logic [1:0]       mode_i;
  logic [7:0]       rx_data;
  logic             rx_valid;
  logic             rx_ready;
  logic [7:0]       tx_data;
  logic             tx_valid;
  logic             tx_ready;
  logic [1:0]       mode_o;
  logic [LW-1:0]    level;
  logic             act;
  logic [CNT_W-1:0] drop;

  logic             s_rx_valid;
  logic             s_rx_ready;
  logic [7:0]       s_tx_data;
  logic             s_tx_valid;
  logic [1:0]       s_mode_o;
  logic [2:0]       s_level;
  logic             s_act;
  logic [1:0]       s_drop;

  always #5 clk = ~clk;

  loopback_fifo #(
    .DEPTH(DEPTH), .ACT_CYCLES(ACT), .EOL_CHAR(8'h0A), .CNT_W(CNT_W)
  ) dut (
    .clk_i(clk), .rstn_i(rstn), .mode_i(mode_i),
    .rx_data_i(rx_data), .rx_valid_i(rx_valid), .rx_ready_o(rx_ready),
    .tx_data_o(tx_data), .tx_valid_o(tx_valid), .tx_ready_i(tx_ready),
    .mode_o(mode_o), .level_o(level), .act_o(act), .drop_cnt_o(drop)
  );

  loopback_fifo #(
    .DEPTH(4), .ACT_CYCLES(3), .EOL_CHAR(8'h0A), .CNT_W(2)
  ) dut_sat (
    .clk_i(clk), .rstn_i(rstn), .mode_i(2'd3),
    .rx_data_i(8'h55), .rx_valid_i(s_rx_valid), .rx_ready_o(s_rx_ready),
    .tx_data_o(s_tx_data), .tx_valid_o(s_tx_valid), .tx_ready_i(1'b0),
    .mode_o(s_mode_o), .level_o(s_level), .act_o(s_act), .drop_cnt_o(s_drop)
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
    end
  endtask

  task automatic timeout_fail(input string name);
    checks++;
    errors++;
    $display("FAIL %s: wait budget expired at %0t", name, $time);
  endtask

  // Reference model: FIFO contents as a plain queue, mode, drop count, activity timer.
  logic [7:0] q[$];
  int mode_m = 0;
  int drop_m = 0;
  int rem    = 0;
  int peak   = 0;
  bit rx_f, tx_f, empty_b, wr_m, exp_valid;

  function automatic logic [7:0] up(input logic [7:0] b);
    return (b >= 8'h61 && b <= 8'h7A) ? b - 8'h20 : b;
  endfunction

  function automatic bit has_eol();
    foreach (q[i]) if (q[i] == 8'h0A) return 1'b1;
    return 1'b0;
  endfunction

  always @(negedge clk) begin
    if (!rstn) begin
      q.delete();
      mode_m = 0;
      drop_m = 0;
      rem    = 0;
    end else begin
      if (int'(level) > peak) peak = int'(level);
      exp_valid = (q.size() > 0) && (mode_m != 2 || has_eol() || q.size() == DEPTH);
      chk("level", 32'(level), 32'(q.size()));
      chk("rx_ready", 32'(rx_ready), 32'(mode_m == 3 || q.size() < DEPTH));
      chk("tx_valid", 32'(tx_valid), 32'(exp_valid));
      chk("mode_o", 32'(mode_o), 32'(mode_m));
      chk("drop_cnt", 32'(drop), 32'(drop_m));
      chk("act", 32'(act), 32'(rem != 0));
      if (tx_valid && q.size() > 0) chk("tx_data", 32'(tx_data), 32'(q[0]));

      rx_f    = rx_valid && rx_ready;
      tx_f    = tx_valid && tx_ready;
      empty_b = (q.size() == 0);
      if (tx_f && q.size() > 0) void'(q.pop_front());
      wr_m = rx_f && mode_m != 3;
      if (wr_m) q.push_back(mode_m == 1 ? up(rx_data) : rx_data);
      if (rx_f && mode_m == 3 && drop_m < (2**CNT_W - 1)) drop_m++;
      if (rx_f || tx_f) rem = ACT;
      else if (rem > 0) rem--;
      if (empty_b && !wr_m) mode_m = int'(mode_i);
    end
  end

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [7:0] b);
    int budget = 200;
    bit acc = 1'b0;
    rx_data  = b;
    rx_valid = 1'b1;
    while (!acc && budget > 0) begin
      @(negedge clk);
      acc = rx_ready;
      @(posedge clk);
      #1;
      budget--;
    end
    rx_valid = 1'b0;
    if (!acc) timeout_fail("send");
  endtask

  task automatic wait_drain(input int budget);
    while (q.size() != 0 && budget > 0) begin
      cyc(1);
      budget--;
    end
    if (q.size() != 0) timeout_fail("drain");
  endtask

  initial begin
    #2000000;
    $display("FAIL global_timeout at %0t", $time);
    $fatal(1, "simulation time limit");
  end

  initial begin
    logic [7:0] b;
    mode_i = 2'd0; rx_data = 8'h00; rx_valid = 1'b0; tx_ready = 1'b0;
    s_rx_valid = 1'b0; rstn = 1'b0;
    cyc(2);
    chk("rst_level", 32'(level), 32'd0);
    chk("rst_tx_valid", 32'(tx_valid), 32'd0);
    chk("rst_rx_ready", 32'(rx_ready), 32'd1);
    chk("rst_mode_o", 32'(mode_o), 32'd0);
    chk("rst_act", 32'(act), 32'd0);
    chk("rst_drop", 32'(drop), 32'd0);
    rstn = 1'b1;
    cyc(2);

    // echo with a free-running sink
    peak = 0;
    tx_ready = 1'b1;
    send(8'h41);
    send(8'h0A);
    wait_drain(50);
    cyc(ACT + 5);
    chk("echo_level_peak", 32'(peak), 32'd1);
    chk("act_idle", 32'(act), 32'd0);

    // fill to full with a stalled sink, then drain across the pointer wrap
    tx_ready = 1'b0;
    for (int i = 0; i < DEPTH; i++) send(8'h30 + 8'(i));
    rx_data = 8'hEE;
    rx_valid = 1'b1;
    cyc(2);
    chk("full_rx_ready", 32'(rx_ready), 32'd0);
    chk("full_level", 32'(level), 32'(DEPTH));
    rx_valid = 1'b0;
    tx_ready = 1'b1;
    wait_drain(100);
    send(8'hEE);
    send(8'hEF);
    wait_drain(50);
    cyc(2);

    // uppercase
    mode_i = 2'd1;
    cyc(3);
    chk("mode_upper", 32'(mode_o), 32'd1);
    send(8'h61); send(8'h5A); send(8'h7B); send(8'h7A);
    wait_drain(50);
    cyc(2);

    // line mode
    mode_i = 2'd2;
    cyc(3);
    chk("mode_line", 32'(mode_o), 32'd2);
    send(8'h61); send(8'h62);
    cyc(5);
    chk("line_gated", 32'(tx_valid), 32'd0);
    send(8'h0A);
    wait_drain(50);
    cyc(2);
    tx_ready = 1'b0;
    for (int i = 0; i < DEPTH; i++) send(8'h41 + 8'(i));
    cyc(2);
    chk("line_full_override", 32'(tx_valid), 32'd1);
    tx_ready = 1'b1;
    cyc(3);
    send(8'h0A);
    wait_drain(100);
    cyc(2);

    // discard
    mode_i = 2'd3;
    cyc(3);
    chk("mode_drop", 32'(mode_o), 32'd3);
    for (int i = 0; i < 5; i++) send(8'($urandom));
    cyc(1);
    chk("drop_five", 32'(drop), 32'd5);
    chk("drop_no_tx", 32'(tx_valid), 32'd0);
    s_rx_valid = 1'b1;
    cyc(5);
    s_rx_valid = 1'b0;
    cyc(1);
    chk("drop_saturate", 32'(s_drop), 32'd3);

    // mode change deferred until drained
    mode_i = 2'd0;
    cyc(3);
    tx_ready = 1'b0;
    send(8'h11); send(8'h12); send(8'h13);
    mode_i = 2'd1;
    cyc(5);
    chk("mode_held", 32'(mode_o), 32'd0);
    tx_ready = 1'b1;
    wait_drain(50);
    cyc(2);
    chk("mode_applied", 32'(mode_o), 32'd1);

    // reset mid-stream
    tx_ready = 1'b0;
    mode_i = 2'd0;
    cyc(3);
    send(8'h21); send(8'h22); send(8'h23);
    @(posedge clk);
    #3;
    rstn = 1'b0;
    #1;
    chk("midrst_level", 32'(level), 32'd0);
    chk("midrst_tx_valid", 32'(tx_valid), 32'd0);
    cyc(2);
    rstn = 1'b1;
    cyc(2);

    // randomised traffic
    for (int c = 0; c < 3000; c++) begin
      if (c % 64 == 0) mode_i = 2'($urandom_range(0, 3));
      rx_valid = ($urandom_range(0, 2) != 0);
      case ($urandom_range(0, 3))
        0:       b = 8'h0A;
        1:       b = 8'($urandom_range(8'h61, 8'h7A));
        default: b = 8'($urandom);
      endcase
      rx_data  = b;
      tx_ready = ($urandom_range(0, 3) != 0);
      cyc(1);
    end
    rx_valid = 1'b0;
    tx_ready = 1'b1;
    cyc(2);
    if (q.size() != 0) send(8'h0A);
    wait_drain(200);
    cyc(2);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
